// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states
// and the default operand width.
package mdu_pkg;

  localparam int MDU_N = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath. The accumulator packs {hi, lo}: for
// multiply hi is the partial product and lo the multiplier (LSB first); for
// divide hi is the partial remainder and lo the dividend/quotient shift register.
module mdu_step #(
  parameter int N = 32
) (
  input  logic           div_i,
  input  logic [2*N-1:0] acc_i,
  input  logic [N-1:0]   opd_i,
  output logic [2*N-1:0] acc_o,
  output logic           qbit_o
);

  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    acc_o   = acc_i;
    qbit_o  = 1'b0;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (div_i) begin
      // Restoring step: the borrow out of the N+1 bit subtract decides the bit.
      shifted = acc_i[2*N-1:N-1];
      diff    = shifted - {1'b0, opd_i};
      qbit_o  = ~diff[N];
      acc_o   = {(qbit_o ? diff[N-1:0] : shifted[N-1:0]), acc_i[N-2:0], 1'b0};
    end else begin
      sum   = {1'b0, acc_i[2*N-1:N]} + (acc_i[0] ? {1'b0, opd_i} : '0);
      acc_o = {sum, acc_i[N-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative N-bit multiply/divide unit with HI/LO registers. Magnitudes are
// processed for N cycles, then signs are applied in a single FIX cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         Clock,
  input  logic         R,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         HiWe,
  input  logic         LoWe,
  input  logic [N-1:0] WData,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo
);

  localparam int CW = $clog2(N) + 1;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   opd_q, opd_d;
  logic [N-1:0]   araw_q, araw_d;
  logic [N-1:0]   hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic           div_q, div_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           divz_q, divz_d;
  logic           done_q, done_d;

  op_e            op;
  logic           sgn_op;
  logic [N-1:0]   a_mag, b_mag;
  logic [2*N-1:0] step_acc;
  logic           step_qbit;
  logic [2*N-1:0] prod;

  assign op     = op_e'(Op);
  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag  = (sgn_op && A[N-1]) ? -A : A;
  assign b_mag  = (sgn_op && B[N-1]) ? -B : B;
  assign prod   = negq_q ? -acc_q : acc_q;

  mdu_step #(.N(N)) u_step (
    .div_i  (div_q),
    .acc_i  (acc_q),
    .opd_i  (opd_q),
    .acc_o  (step_acc),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    araw_d  = araw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (HiWe) hi_d = WData;
        if (LoWe) lo_d = WData;
        if (Start) begin
          acc_d   = {{N{1'b0}}, a_mag};
          opd_d   = b_mag;
          araw_d  = A;
          div_d   = (op == OP_DIVU) || (op == OP_DIV);
          negq_d  = sgn_op && (A[N-1] ^ B[N-1]);
          negr_d  = sgn_op && A[N-1];
          divz_d  = ((op == OP_DIVU) || (op == OP_DIV)) && (B == '0);
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = step_acc | {{(2*N-1){1'b0}}, step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q && divz_q) begin
          lo_d = '1;
          hi_d = araw_q;
        end else if (div_q) begin
          lo_d = negq_q ? -acc_q[N-1:0] : acc_q[N-1:0];
          hi_d = negr_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!R) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      araw_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      araw_q  <= araw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes reference {Hi,Lo}
// results, a monitor pops and compares on every Done pulse.
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        R, Start, HiWe, LoWe;
  logic [1:0]  Op;
  logic [31:0] A, B, WData;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 Clock = ~Clock;

  mult_div_unit dut (
    .Clock(Clock), .R(R), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWe(HiWe), .LoWe(LoWe), .WData(WData),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      2'd0: r = {32'b0, a} * {32'b0, b};
      2'd1: r = 64'(sa * sb);
      default: begin
        if (b == 32'd0)      r = {a, 32'hFFFF_FFFF};
        else if (op == 2'd2) r = {a % b, a / b};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  always @(negedge Clock) begin
    if (R && Done) begin
      chk("done_with_busy", 64'(Busy), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Hi=%h Lo=%h expected no Done", Hi, Lo);
      end else begin
        chk("result", {Hi, Lo}, exp_q.pop_front());
      end
    end
  end

  // Issue one op, optionally with an mthi/mtlo on the same edge; then verify
  // Busy length and the Done pulse shape. Result itself is checked by the monitor.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit wr);
    int bc;
    bit seen;
    @(negedge Clock);
    Start = 1'b1; Op = op; A = a; B = b;
    if (wr) begin HiWe = 1'b1; LoWe = 1'b1; WData = 32'hA5A5_0F0F; end
    exp_q.push_back(model(op, a, b));
    @(negedge Clock);
    Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
    A = $urandom; B = $urandom; Op = 2'($urandom);
    if (wr) chk("same_edge_write", {Hi, Lo}, {32'hA5A5_0F0F, 32'hA5A5_0F0F});
    bc = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (Busy) bc++;
      if (Done) seen = 1;
      else @(negedge Clock);
    end
    chk("busy_len", 64'(bc), 64'd33);
    chk("done_seen", 64'(seen), 64'd1);
    @(negedge Clock);
    chk("done_pulse_end", 64'(Done), 64'd0);
  endtask

  initial begin
    R = 1'b0; Start = 1'b0; HiWe = 1'b0; LoWe = 1'b0;
    Op = '0; A = '0; B = '0; WData = '0;
    repeat (2) @(negedge Clock);
    chk("reset_hi", 64'(Hi), 64'd0);
    chk("reset_lo", 64'(Lo), 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    R = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 0);
    chk("mult_neg", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
    chk("mult_minmin", {Hi, Lo}, 64'h4000_0000_0000_0000);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_neg", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd100, 32'd7, 0);
    chk("divu", {Hi, Lo}, {32'd2, 32'd14});
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf", {Hi, Lo}, 64'h0000_0000_8000_0000);
    run_op(2'd2, 32'd100, 32'd0, 0);
    chk("divu_zero", {Hi, Lo}, {32'd100, 32'hFFFF_FFFF});
    run_op(2'd3, 32'hFFFF_FF00, 32'd0, 0);
    run_op(2'd0, 32'd3, 32'd4, 1);
    chk("write_overwritten", {Hi, Lo}, {32'd0, 32'd12});

    // Start/HiWe while busy are ignored.
    @(negedge Clock);
    Start = 1'b1; Op = 2'd0; A = 32'd5; B = 32'd6;
    exp_q.push_back(model(2'd0, 32'd5, 32'd6));
    @(negedge Clock);
    Start = 1'b0;
    repeat (8) @(negedge Clock);
    Start = 1'b1; Op = 2'd2; A = 32'd77; B = 32'd3;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    HiWe = 1'b1; WData = 32'hDEAD_BEEF;
    @(negedge Clock);
    HiWe = 1'b0;
    repeat (30) @(negedge Clock);
    chk("busy_ignore", {Hi, Lo}, {32'd0, 32'd30});
    chk("busy_ignore_idle", 64'(Busy), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 8 == 3) ? 32'd0 : ((i % 4 == 1) ? 32'($urandom_range(1, 50)) : $urandom);
      if (i % 8 == 5) ra = 32'h8000_0000;
      run_op(2'(i % 4), ra, rb, 0);
    end

    // Reset mid-operation discards it; mthi then works from IDLE.
    @(negedge Clock);
    Start = 1'b1; Op = 2'd1; A = 32'd1234; B = 32'd5678;
    @(negedge Clock);
    Start = 1'b0;
    repeat (8) @(negedge Clock);
    R = 1'b0;
    @(negedge Clock);
    R = 1'b1;
    chk("midreset_busy", 64'(Busy), 64'd0);
    chk("midreset_hilo", {Hi, Lo}, 64'd0);
    repeat (40) @(negedge Clock);
    chk("midreset_no_result", {Hi, Lo}, 64'd0);
    HiWe = 1'b1; WData = 32'h0000_1234;
    @(negedge Clock);
    HiWe = 1'b0;
    chk("mthi", {Hi, Lo}, {32'h0000_1234, 32'd0});
    LoWe = 1'b1; WData = 32'h0000_5678;
    @(negedge Clock);
    LoWe = 1'b0;
    chk("mtlo", {Hi, Lo}, {32'h0000_1234, 32'h0000_5678});

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
